matmul_sequencer: RTL
=====================

Name: matmul_sequencer

Overview:
- Front-end and back-end sequencer for the 2x2 matrix-multiply datapath.
- Accepts a stream of 8 operand bytes over a valid/ready handshake, in the order A00, A01, A10, A11, B00, B01, B10, B11.
- Drives the multiplier's element-select, value and execute inputs, then sweeps its result-select.
- Returns the four 17-bit products C00, C01, C10, C11 over a second valid/ready handshake. Sits between the wishbone/IO glue and the multiplier core.

Parameters:
- DATA_W, 8, operand width.
- RES_W, 17, result width; must be at least 2*DATA_W+1.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort; returns to LOAD with element count 0.
- in_valid  input  1  operand byte valid.
- in_data  input  DATA_W  operand byte.
- in_ready  output  1  sequencer can accept a byte.
- mm_sel_in  output  3  element index driven to the multiplier.
- mm_input_val  output  DATA_W  element value driven to the multiplier.
- mm_execute  output  1  0 = load mode, 1 = compute/read mode.
- mm_sel_out  output  2  result index: 0=C00, 1=C01, 2=C10, 3=C11.
- mm_result  input  RES_W  combinational product selected by mm_sel_out.
- out_valid  output  1  result valid.
- out_data  output  RES_W  captured result.
- out_last  output  1  high with the C11 result.
- busy  output  1  high in any state other than LOAD.

Behaviour:
- Reset values: all outputs 0; state LOAD; element count 0; result index 0. in_ready is combinational and goes to 1 once reset deasserts.
- State LOAD:
  - in_ready=1 and mm_execute=0.
  - On in_valid&&in_ready: mm_sel_in<=count, mm_input_val<=in_data, count<=count+1.
  - mm_sel_in and mm_input_val are registers that change only on an accept and are otherwise held. The multiplier rewrites the currently selected element every load-mode cycle, so holding these registers makes the rewrite idempotent.
  - A byte accepted at edge k appears on mm_* after edge k and is written into the multiplier at edge k+1.
  - After the 8th accept (count wraps 7->0), go to SETTLE. in_ready drops in the same cycle the state changes, so a 9th byte is never accepted.
- State SETTLE: one cycle, so B11 is written. Then mm_execute<=1, mm_sel_out<=0, go to CAPTURE.
- State CAPTURE: out_data<=mm_result, out_valid<=1, out_last<=(idx==3), go to WAIT.
- State WAIT: hold out_valid, out_data and out_last stable until out_ready.
  - On out_valid&&out_ready with idx<3: out_valid<=0, idx<=idx+1, mm_sel_out<=idx+1, go to CAPTURE.
  - On out_valid&&out_ready with idx==3: out_valid<=0, out_last<=0, idx<=0, mm_sel_out<=0, mm_execute<=0, go to LOAD.
- Throughput: one result per 2 cycles when out_ready is held high. Load-to-first-result latency: 3 cycles after the 8th accept edge.
- Width: products are not truncated; max 2*(2^DATA_W-1)^2 = 130050 for DATA_W=8, which fits in 17 bits.
- clear:
  - Takes priority over every handshake in the same cycle.
  - From any state: go to LOAD; count, idx, out_valid, out_last and mm_execute <= 0. mm_sel_in and mm_input_val are held.
  - A partial load is discarded; matrix contents already written in the multiplier are stale and are overwritten by the next load.
- Reset mid-operation: async return to the full reset state. Any pending output beat is lost.
- Simultaneous in_valid and clear: the byte is not accepted.
- out_ready while out_valid=0 is ignored.

Decomposition:
- Shared package holds:
  - State encoding: LOAD, SETTLE, CAPTURE, WAIT.
  - Element index constants: IDX_A00=0 .. IDX_B11=7.
  - Result index constants: C00=0 .. C11=3.
  - N_ELEM=8 and N_RES=4.
- No sub-module needed. The element counter and result index are inline registers. An optional small handshake output register (out_valid/out_data/out_last) may be split out as matmul_out_reg.

Test Plan:
- Identity times value: A=[[1,0],[0,1]], B=[[5,6],[7,8]], out_ready=1 -> results 5, 6, 7, 8; out_last only on 8; busy drops 1 cycle after the last handshake.
- Max operands: all 8 bytes=255 -> four results each 130050; no overflow.
- Backpressure: A=[[1,2],[3,4]], B=[[5,6],[7,8]]; out_ready low for 5 cycles per beat -> 19, 22, 43, 50, each held stable while stalled; never more than 4 beats.
- Back-to-back jobs: second job A=[[2,0],[0,2]], B=[[1,1],[1,1]] in_valid'd during the first job's WAIT -> in_ready=0 until LOAD; then 2, 2, 2, 2.
- Reset mid-load after 5 bytes: outputs return to 0, in_ready=1 next cycle; a fresh 8-byte load gives correct results.
- Clear in WAIT at idx 1 with in_valid=1: out_valid=0 next cycle, mm_execute=0, byte not accepted; the next full load produces correct 4 beats.

Source files
------------

// File: rtl/matmul_sequencer_pkg.sv
// Shared definitions for the 2x2 matrix-multiply sequencer: state encoding,
// operand/result index constants and element counts.
package matmul_sequencer_pkg;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      WAIT    = 2'd3
   } state_t;

   localparam int N_ELEM = 8;
   localparam int N_RES  = 4;

   localparam logic [2:0] IDX_A00 = 3'd0;
   localparam logic [2:0] IDX_A01 = 3'd1;
   localparam logic [2:0] IDX_A10 = 3'd2;
   localparam logic [2:0] IDX_A11 = 3'd3;
   localparam logic [2:0] IDX_B00 = 3'd4;
   localparam logic [2:0] IDX_B01 = 3'd5;
   localparam logic [2:0] IDX_B10 = 3'd6;
   localparam logic [2:0] IDX_B11 = 3'd7;

   localparam logic [1:0] C00 = 2'd0;
   localparam logic [1:0] C01 = 2'd1;
   localparam logic [1:0] C10 = 2'd2;
   localparam logic [1:0] C11 = 2'd3;

   // True when the result index points at the final product of a job.
   function automatic logic is_last_res(input logic [1:0] idx);
      return (idx == C11);
   endfunction

endpackage

// File: rtl/matmul_sequencer.sv
// Sequencer between the byte-stream IO glue and the 2x2 multiplier core.
// Loads eight operand bytes into the multiplier, lets the last write settle,
// then sweeps the four products out over a valid/ready handshake.
module matmul_sequencer
   import matmul_sequencer_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int RES_W  = 17
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [2:0]        mm_sel_in,
   output logic [DATA_W-1:0] mm_input_val,
   output logic              mm_execute,
   output logic [1:0]        mm_sel_out,
   input  logic [RES_W-1:0]  mm_result,
   output logic              out_valid,
   output logic [RES_W-1:0]  out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              busy
);

   state_t     state_r;
   logic [2:0] count_r;
   logic [1:0] idx_r;
   logic       accept_s;

   // Bytes are only taken in LOAD and never while reset is held.
   assign in_ready = (state_r == LOAD) && !reset;

   // An abort in the same cycle wins over the input handshake.
   assign accept_s = in_valid && in_ready && !clear;

   // Main sequencer: load counter, settle cycle, capture/handshake of results.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= LOAD;
         count_r      <= 3'd0;
         idx_r        <= 2'd0;
         mm_sel_in    <= 3'd0;
         mm_input_val <= '0;
         mm_execute   <= 1'b0;
         mm_sel_out   <= 2'd0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_last     <= 1'b0;
         busy         <= 1'b0;
      end else if (clear) begin
         // Element select/value are held: rewriting the same element is harmless.
         state_r    <= LOAD;
         count_r    <= 3'd0;
         idx_r      <= 2'd0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         mm_execute <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state_r)
            LOAD: begin
               if (accept_s) begin
                  mm_sel_in    <= count_r;
                  mm_input_val <= in_data;
                  count_r      <= count_r + 3'd1;
                  if (count_r == IDX_B11) begin
                     state_r <= SETTLE;
                     busy    <= 1'b1;
                  end
               end
            end
            SETTLE: begin
               // B11 is written by the multiplier on this edge.
               mm_execute <= 1'b1;
               mm_sel_out <= C00;
               state_r    <= CAPTURE;
            end
            CAPTURE: begin
               out_data  <= mm_result;
               out_valid <= 1'b1;
               out_last  <= is_last_res(idx_r);
               state_r   <= WAIT;
            end
            WAIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (is_last_res(idx_r)) begin
                     out_last   <= 1'b0;
                     idx_r      <= 2'd0;
                     mm_sel_out <= C00;
                     mm_execute <= 1'b0;
                     state_r    <= LOAD;
                     busy       <= 1'b0;
                  end else begin
                     idx_r      <= idx_r + 2'd1;
                     mm_sel_out <= idx_r + 2'd1;
                     state_r    <= CAPTURE;
                  end
               end
            end
            default: begin
               state_r    <= LOAD;
               count_r    <= 3'd0;
               idx_r      <= 2'd0;
               out_valid  <= 1'b0;
               out_last   <= 1'b0;
               mm_execute <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
